eth_idma_desc_sched: RTL and testbench
======================================

Name: eth_idma_desc_sched

Overview:
- Descriptor scheduler that sits directly upstream of the iDMA backend in the Ethernet DMA subsystem. It replaces single-shot register-driven req_valid pulses.
- Buffers software-pushed TX descriptors (memory→AXIS) and RX descriptors (AXIS→memory) in a FIFO, then issues them to the backend over a valid/ready request channel.
- Tracks in-flight transfers, retires in-order backend responses, and reports completions, errors and interrupts.

Parameters:
- AddrWidth, 32, width of source/destination addresses.
- LenWidth, 32, width of transfer length in bytes.
- DescDepth, 4, descriptor FIFO entries; power of 2, ≥2.
- MaxOutstanding, 3, maximum requests accepted by the backend but not yet responded; ≥1.
- CntWidth, 16, width of the completion counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- desc_valid_i  in  1  descriptor push valid.
- desc_ready_o  out  1  FIFO not full.
- desc_src_addr_i  in  AddrWidth  source address.
- desc_dst_addr_i  in  AddrWidth  destination address.
- desc_len_i  in  LenWidth  length in bytes.
- desc_dir_i  in  1  0 = TX (src AXI, dst AXIS); 1 = RX (src AXIS, dst AXI).
- desc_irq_en_i  in  1  raise irq on completion.
- req_valid_o  out  1  request to backend.
- req_ready_i  in  1  backend accepts request.
- req_src_addr_o  out  AddrWidth  head source address.
- req_dst_addr_o  out  AddrWidth  head destination address.
- req_len_o  out  LenWidth  head length.
- req_dir_o  out  1  head direction; sets src/dst protocol.
- rsp_valid_i  in  1  backend response.
- rsp_ready_o  out  1  always 1 out of reset.
- rsp_error_i  in  1  response carries error.
- irq_clr_i  in  1  clear irq_o.
- err_clr_i  in  1  clear err_o and leave HALT.
- pending_o  out  $clog2(DescDepth+1)  FIFO occupancy.
- outstanding_o  out  $clog2(MaxOutstanding+1)  in-flight count.
- done_cnt_o  out  CntWidth  completed descriptors, wraps.
- irq_o  out  1  sticky completion interrupt.
- err_o  out  2  [0] transfer error, [1] spurious response; sticky.
- busy_o  out  1  pending_o != 0 or outstanding_o != 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - All outputs 0, including rsp_ready_o.
  - desc_ready_o is 1 from the first cycle after reset.
  - FIFO, in-flight tracker and state cleared.
  - Reset mid-transfer drops all descriptors and in-flight records with no handshake completion.
- Push: accepted when desc_valid_i && desc_ready_o.
  - Push into an empty FIFO makes the head visible the next cycle (one-cycle latency to req_valid_o).
  - Simultaneous push and pop when full is not allowed (desc_ready_o = 0 when full). When non-full, both occur and pending_o is unchanged.
- FSM states: RUN, HALT.
  - RUN → HALT when a response with rsp_error_i = 1 is retired.
  - HALT → RUN on err_clr_i.
  - In HALT, no new request is started. In-flight responses are still retired.
- Issue: req_valid_o is asserted when all of the following hold:
  - state is RUN;
  - FIFO is not empty;
  - head len != 0;
  - outstanding < MaxOutstanding.
- Issue hold rule: once req_valid_o is asserted, it and the payload hold until req_ready_i, even if HALT is entered meanwhile. This needs an internal "offered" flag.
- Handshake (req_valid_o && req_ready_i):
  - pops the head;
  - outstanding +1;
  - pushes {irq_en} into an in-flight tracker FIFO of depth MaxOutstanding.
- Zero-length head (RUN only): popped without issuing, one per cycle, and completed immediately (done_cnt +1; irq if irq_en).
- Response: retired when rsp_valid_i and outstanding > 0.
  - Pops the tracker; outstanding −1; done_cnt +1.
  - Sets irq_o if the retired entry's irq_en = 1.
  - rsp_error_i sets err_o[0].
  - A retire and an issue in the same cycle leave outstanding unchanged.
- Spurious response: rsp_valid_i with outstanding == 0 is ignored, except that it sets err_o[1].
- Same-cycle zero-length completion and response retire: done_cnt increments by 2.
- done_cnt wraps modulo 2^CntWidth.
- Set priority: irq set beats irq_clr_i in the same cycle; err set beats err_clr_i in the same cycle. In the err case, state stays HALT.

Test Plan:
- Reset, then push TX {src 0x1000, dst 0, len 64}:
  - req_valid_o high in cycle 2 with that payload;
  - req_ready_i held 0 for 3 cycles → valid and payload stable;
  - ready → pending 0, outstanding 1.
- Push 4 descriptors with req_ready_i = 0:
  - desc_ready_o = 0 after the 4th;
  - a 5th push is not accepted;
  - pending_o = 4.
- Backend always ready with MaxOutstanding = 3 and 5 descriptors:
  - exactly 3 issued, req_valid_o low until a response arrives;
  - after 5 responses, done_cnt = 5 and busy_o = 0.
- Descriptor len 0 with irq_en = 1:
  - no req_valid_o;
  - done_cnt +1 next cycle, irq_o = 1;
  - irq_clr_i clears it; irq_clr_i coincident with a new irq completion keeps irq_o = 1.
- Response with rsp_error_i while 2 descriptors are queued:
  - err_o = 01, no further issues;
  - err_clr_i → issuing resumes.
- rsp_valid_i with outstanding 0:
  - err_o = 10, done_cnt unchanged.
- done_cnt at 0xFFFF plus one completion:
  - done_cnt = 0x0000.

Source files
------------

// File: rtl/eth_idma_desc_sched.sv
// Descriptor scheduler for the Ethernet iDMA backend.
// Buffers TX/RX descriptors, issues them over a valid/ready request channel,
// tracks in-flight transfers and retires in-order backend responses.
module eth_idma_desc_sched #(
   parameter int AddrWidth      = 32,
   parameter int LenWidth       = 32,
   parameter int DescDepth      = 4,
   parameter int MaxOutstanding = 3,
   parameter int CntWidth       = 16
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 desc_valid_i,
   output logic                                 desc_ready_o,
   input  logic [AddrWidth-1:0]                 desc_src_addr_i,
   input  logic [AddrWidth-1:0]                 desc_dst_addr_i,
   input  logic [LenWidth-1:0]                  desc_len_i,
   input  logic                                 desc_dir_i,
   input  logic                                 desc_irq_en_i,
   output logic                                 req_valid_o,
   input  logic                                 req_ready_i,
   output logic [AddrWidth-1:0]                 req_src_addr_o,
   output logic [AddrWidth-1:0]                 req_dst_addr_o,
   output logic [LenWidth-1:0]                  req_len_o,
   output logic                                 req_dir_o,
   input  logic                                 rsp_valid_i,
   output logic                                 rsp_ready_o,
   input  logic                                 rsp_error_i,
   input  logic                                 irq_clr_i,
   input  logic                                 err_clr_i,
   output logic [$clog2(DescDepth+1)-1:0]       pending_o,
   output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
   output logic [CntWidth-1:0]                  done_cnt_o,
   output logic                                 irq_o,
   output logic [1:0]                           err_o,
   output logic                                 busy_o
);

   localparam int PtrW  = $clog2(DescDepth);
   localparam int PendW = $clog2(DescDepth+1);
   localparam int OutW  = $clog2(MaxOutstanding+1);
   localparam int TrkW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   // Descriptor entry layout: {src, dst, len, dir, irq_en}
   localparam int DescW = 2*AddrWidth + LenWidth + 2;

   localparam logic [0:0] StRun  = 1'b0;
   localparam logic [0:0] StHalt = 1'b1;

   // Tracker pointer advance; the tracker depth need not be a power of two.
   function automatic logic [TrkW-1:0] trk_inc(input logic [TrkW-1:0] p);
      if (p == TrkW'(MaxOutstanding-1)) begin
         return {TrkW{1'b0}};
      end else begin
         return p + TrkW'(1);
      end
   endfunction

   logic [DescW-1:0] mem_q [DescDepth];
   logic [DescW-1:0] mem_d [DescDepth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PendW-1:0] count_q, count_d;
   logic             trk_q [MaxOutstanding];
   logic             trk_d [MaxOutstanding];
   logic [TrkW-1:0]  trk_wr_q, trk_wr_d, trk_rd_q, trk_rd_d;
   logic [OutW-1:0]  outstanding_q, outstanding_d;
   logic [CntWidth-1:0] done_cnt_q, done_cnt_d;
   logic [0:0]       state_q, state_d;
   logic             offered_q, offered_d;
   logic             irq_q, irq_d;
   logic [1:0]       err_q, err_d;
   logic             desc_ready_q, desc_ready_d;
   logic             rsp_ready_q;
   logic             busy_q, busy_d;

   logic [DescW-1:0] head_s;
   logic             empty_s, len_zero_s, can_issue_s, req_valid_s;
   logic             handshake_s, zero_pop_s, pop_s, push_s, retire_s, spurious_s;

   assign head_s      = mem_q[rd_ptr_q];
   assign empty_s     = (count_q == PendW'(0));
   assign len_zero_s  = (head_s[2 +: LenWidth] == LenWidth'(0));
   assign can_issue_s = (state_q == StRun) && !empty_s && !len_zero_s &&
                        (outstanding_q < OutW'(MaxOutstanding));
   // Once offered, the request is held until accepted, even across HALT.
   assign req_valid_s = offered_q || can_issue_s;
   assign handshake_s = req_valid_s && req_ready_i;
   assign zero_pop_s  = (state_q == StRun) && !empty_s && len_zero_s && !offered_q;
   assign pop_s       = handshake_s || zero_pop_s;
   assign push_s      = desc_valid_i && desc_ready_q;
   assign retire_s    = rsp_valid_i && (outstanding_q != OutW'(0));
   assign spurious_s  = rsp_valid_i && (outstanding_q == OutW'(0));

   assign desc_ready_o   = desc_ready_q;
   assign req_valid_o    = req_valid_s;
   assign req_src_addr_o = head_s[2+LenWidth+AddrWidth +: AddrWidth];
   assign req_dst_addr_o = head_s[2+LenWidth +: AddrWidth];
   assign req_len_o      = head_s[2 +: LenWidth];
   assign req_dir_o      = head_s[1];
   assign rsp_ready_o    = rsp_ready_q;
   assign pending_o      = count_q;
   assign outstanding_o  = outstanding_q;
   assign done_cnt_o     = done_cnt_q;
   assign irq_o          = irq_q;
   assign err_o          = err_q;
   assign busy_o         = busy_q;

   // Descriptor FIFO and in-flight tracker next-state.
   always_comb begin
      mem_d    = mem_q;
      trk_d    = trk_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      trk_wr_d = trk_wr_q;
      trk_rd_d = trk_rd_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = {desc_src_addr_i, desc_dst_addr_i, desc_len_i,
                            desc_dir_i, desc_irq_en_i};
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (handshake_s) begin
         trk_d[trk_wr_q] = head_s[0];
         trk_wr_d = trk_inc(trk_wr_q);
      end else begin
         trk_wr_d = trk_wr_q;
      end
      if (retire_s) begin
         trk_rd_d = trk_inc(trk_rd_q);
      end else begin
         trk_rd_d = trk_rd_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + PendW'(1);
         2'b01:   count_d = count_q - PendW'(1);
         default: count_d = count_q;
      endcase
      case ({handshake_s, retire_s})
         2'b10:   outstanding_d = outstanding_q + OutW'(1);
         2'b01:   outstanding_d = outstanding_q - OutW'(1);
         default: outstanding_d = outstanding_q;
      endcase
      desc_ready_d = (count_d != PendW'(DescDepth));
      busy_d       = (count_d != PendW'(0)) || (outstanding_d != OutW'(0));
   end

   // Run/halt state, offer hold, completion counting and sticky status.
   always_comb begin
      state_d    = state_q;
      offered_d  = offered_q;
      irq_d      = irq_q;
      err_d      = err_q;
      done_cnt_d = done_cnt_q + CntWidth'(zero_pop_s) + CntWidth'(retire_s);
      if (req_valid_s && !req_ready_i) begin
         offered_d = 1'b1;
      end else begin
         offered_d = 1'b0;
      end
      if (retire_s && rsp_error_i) begin
         state_d = StHalt;
      end else if (err_clr_i) begin
         state_d = StRun;
      end else begin
         state_d = state_q;
      end
      if ((zero_pop_s && head_s[0]) || (retire_s && trk_q[trk_rd_q])) begin
         irq_d = 1'b1;
      end else if (irq_clr_i) begin
         irq_d = 1'b0;
      end else begin
         irq_d = irq_q;
      end
      if (retire_s && rsp_error_i) begin
         err_d[0] = 1'b1;
      end else if (err_clr_i) begin
         err_d[0] = 1'b0;
      end else begin
         err_d[0] = err_q[0];
      end
      if (spurious_s) begin
         err_d[1] = 1'b1;
      end else if (err_clr_i) begin
         err_d[1] = 1'b0;
      end else begin
         err_d[1] = err_q[1];
      end
   end

   // State registers with synchronous reset; reset drops all queued and in-flight work.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q         <= '{default: {DescW{1'b0}}};
         trk_q         <= '{default: 1'b0};
         wr_ptr_q      <= {PtrW{1'b0}};
         rd_ptr_q      <= {PtrW{1'b0}};
         trk_wr_q      <= {TrkW{1'b0}};
         trk_rd_q      <= {TrkW{1'b0}};
         count_q       <= {PendW{1'b0}};
         outstanding_q <= {OutW{1'b0}};
         done_cnt_q    <= {CntWidth{1'b0}};
         state_q       <= StRun;
         offered_q     <= 1'b0;
         irq_q         <= 1'b0;
         err_q         <= 2'b00;
         desc_ready_q  <= 1'b0;
         rsp_ready_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         mem_q         <= mem_d;
         trk_q         <= trk_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         trk_wr_q      <= trk_wr_d;
         trk_rd_q      <= trk_rd_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         done_cnt_q    <= done_cnt_d;
         state_q       <= state_d;
         offered_q     <= offered_d;
         irq_q         <= irq_d;
         err_q         <= err_d;
         desc_ready_q  <= desc_ready_d;
         rsp_ready_q   <= 1'b1;
         busy_q        <= busy_d;
      end
   end

endmodule

// File: tb/tb_eth_idma_desc_sched.sv
// Directed self-checking bench for eth_idma_desc_sched.
module tb_eth_idma_desc_sched;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        desc_valid_i;
   logic        desc_ready_o;
   logic [31:0] desc_src_addr_i;
   logic [31:0] desc_dst_addr_i;
   logic [31:0] desc_len_i;
   logic        desc_dir_i;
   logic        desc_irq_en_i;
   logic        req_valid_o;
   logic        req_ready_i;
   logic [31:0] req_src_addr_o;
   logic [31:0] req_dst_addr_o;
   logic [31:0] req_len_o;
   logic        req_dir_o;
   logic        rsp_valid_i;
   logic        rsp_ready_o;
   logic        rsp_error_i;
   logic        irq_clr_i;
   logic        err_clr_i;
   logic [2:0]  pending_o;
   logic [1:0]  outstanding_o;
   logic [15:0] done_cnt_o;
   logic        irq_o;
   logic [1:0]  err_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   eth_idma_desc_sched dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
      .desc_src_addr_i(desc_src_addr_i), .desc_dst_addr_i(desc_dst_addr_i),
      .desc_len_i(desc_len_i), .desc_dir_i(desc_dir_i), .desc_irq_en_i(desc_irq_en_i),
      .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
      .req_src_addr_o(req_src_addr_o), .req_dst_addr_o(req_dst_addr_o),
      .req_len_o(req_len_o), .req_dir_o(req_dir_o),
      .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_error_i(rsp_error_i),
      .irq_clr_i(irq_clr_i), .err_clr_i(err_clr_i),
      .pending_o(pending_o), .outstanding_o(outstanding_o), .done_cnt_o(done_cnt_o),
      .irq_o(irq_o), .err_o(err_o), .busy_o(busy_o)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_desc(input logic [31:0] src, input logic [31:0] dst,
                           input logic [31:0] len, input logic dir, input logic irq);
      desc_src_addr_i = src;
      desc_dst_addr_i = dst;
      desc_len_i      = len;
      desc_dir_i      = dir;
      desc_irq_en_i   = irq;
   endtask

   // Linear sequence of directed steps.
   initial begin
      rst_i = 1'b1; desc_valid_i = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b0;
      rsp_error_i = 1'b0; irq_clr_i = 1'b0; err_clr_i = 1'b0;
      set_desc(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Reset state
      repeat (3) tick();
      chk("rst_desc_ready", desc_ready_o, 0);
      chk("rst_rsp_ready", rsp_ready_o, 0);
      chk("rst_req_valid", req_valid_o, 0);
      chk("rst_pending", pending_o, 0);
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_done", done_cnt_o, 0);
      chk("rst_irq", irq_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_busy", busy_o, 0);
      rst_i = 1'b0;
      tick();
      chk("post_rst_desc_ready", desc_ready_o, 1);
      chk("post_rst_rsp_ready", rsp_ready_o, 1);

      // Single TX descriptor, backend stalls 3 cycles
      set_desc(32'h1000, 32'h0, 32'd64, 1'b0, 1'b0);
      desc_valid_i = 1'b1;
      tick();
      desc_valid_i = 1'b0;
      set_desc(32'hDEAD, 32'hBEEF, 32'd7, 1'b1, 1'b1);
      chk("a_req_valid", req_valid_o, 1);
      chk("a_src", req_src_addr_o, 32'h1000);
      chk("a_dst", req_dst_addr_o, 32'h0);
      chk("a_len", req_len_o, 64);
      chk("a_dir", req_dir_o, 0);
      chk("a_pending", pending_o, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("a_hold_valid", req_valid_o, 1);
         chk("a_hold_src", req_src_addr_o, 32'h1000);
         chk("a_hold_len", req_len_o, 64);
      end
      req_ready_i = 1'b1;
      tick();
      req_ready_i = 1'b0;
      chk("a_hs_pending", pending_o, 0);
      chk("a_hs_outstanding", outstanding_o, 1);
      chk("a_hs_req_valid", req_valid_o, 0);
      rsp_valid_i = 1'b1;
      tick();
      rsp_valid_i = 1'b0;
      chk("a_rsp_outstanding", outstanding_o, 0);
      chk("a_rsp_done", done_cnt_o, 1);
      chk("a_rsp_busy", busy_o, 0);
      chk("a_rsp_err", err_o, 0);

      // Fill the FIFO with the backend stalled
      desc_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_desc(32'h2000 + 32'(i), 32'h3000 + 32'(i), 32'd16, 1'b1, 1'b0);
         tick();
      end
      chk("b_desc_ready_full", desc_ready_o, 0);
      chk("b_pending4", pending_o, 4);
      set_desc(32'h2FFF, 32'h3FFF, 32'd16, 1'b1, 1'b0);
      tick();
      desc_valid_i = 1'b0;
      chk("b_fifth_rejected", pending_o, 4);
      chk("b_head_src", req_src_addr_o, 32'h2000);
      chk("b_head_dir", req_dir_o, 1);

      // Backend always ready: only 3 in flight, then drain with 5 responses
      req_ready_i = 1'b1;
      tick();
      chk("c_hs1_pending", pending_o, 3);
      chk("c_hs1_desc_ready", desc_ready_o, 1);
      set_desc(32'h2004, 32'h3004, 32'd16, 1'b0, 1'b0);
      desc_valid_i = 1'b1;
      tick();
      desc_valid_i = 1'b0;
      chk("c_hs2_pending", pending_o, 3);
      chk("c_hs2_outstanding", outstanding_o, 2);
      tick();
      chk("c_hs3_outstanding", outstanding_o, 3);
      chk("c_max_req_valid", req_valid_o, 0);
      tick();
      chk("c_max_hold_valid", req_valid_o, 0);
      chk("c_max_hold_pending", pending_o, 2);
      rsp_valid_i = 1'b1;
      tick();
      chk("c_r1_outstanding", outstanding_o, 2);
      chk("c_r1_pending", pending_o, 2);
      chk("c_r1_req_valid", req_valid_o, 1);
      tick();
      tick();
      chk("c_r3_outstanding", outstanding_o, 2);
      chk("c_r3_pending", pending_o, 0);
      tick();
      tick();
      rsp_valid_i = 1'b0;
      req_ready_i = 1'b0;
      chk("c_done", done_cnt_o, 6);
      chk("c_busy", busy_o, 0);
      chk("c_outstanding0", outstanding_o, 0);
      chk("c_err", err_o, 0);

      // Zero-length descriptor with irq enable
      set_desc(32'h0, 32'h0, 32'd0, 1'b0, 1'b1);
      desc_valid_i = 1'b1;
      tick();
      desc_valid_i = 1'b0;
      chk("d_no_req_valid", req_valid_o, 0);
      chk("d_done_before", done_cnt_o, 6);
      tick();
      chk("d_done_after", done_cnt_o, 7);
      chk("d_irq_set", irq_o, 1);
      chk("d_pending", pending_o, 0);
      irq_clr_i = 1'b1;
      tick();
      irq_clr_i = 1'b0;
      chk("d_irq_cleared", irq_o, 0);
      desc_valid_i = 1'b1;
      tick();
      desc_valid_i = 1'b0;
      irq_clr_i = 1'b1;
      tick();
      irq_clr_i = 1'b0;
      chk("d_irq_set_beats_clr", irq_o, 1);
      chk("d_done2", done_cnt_o, 8);
      irq_clr_i = 1'b1;
      tick();
      irq_clr_i = 1'b0;
      chk("d_irq_cleared2", irq_o, 0);

      // Error response with 2 descriptors queued, then resume
      req_ready_i = 1'b1;
      desc_valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_desc(32'h4000 + 32'(i), 32'h5000, 32'd8, 1'b0, 1'b0);
         tick();
      end
      desc_valid_i = 1'b0;
      chk("e_pending", pending_o, 2);
      chk("e_outstanding", outstanding_o, 3);
      chk("e_req_valid_max", req_valid_o, 0);
      rsp_valid_i = 1'b1;
      rsp_error_i = 1'b1;
      tick();
      rsp_valid_i = 1'b0;
      rsp_error_i = 1'b0;
      chk("e_err", err_o, 2'b01);
      chk("e_done", done_cnt_o, 9);
      chk("e_halt_req_valid", req_valid_o, 0);
      tick();
      chk("e_halt_pending", pending_o, 2);
      chk("e_halt_outstanding", outstanding_o, 2);
      chk("e_halt_req_valid2", req_valid_o, 0);
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      chk("e_clr_err", err_o, 0);
      chk("e_resume_req_valid", req_valid_o, 1);
      chk("e_resume_src", req_src_addr_o, 32'h4003);
      tick();
      chk("e_resume_pending", pending_o, 1);
      chk("e_resume_outstanding", outstanding_o, 3);
      rsp_valid_i = 1'b1;
      repeat (4) tick();
      rsp_valid_i = 1'b0;
      req_ready_i = 1'b0;
      chk("e_drain_outstanding", outstanding_o, 0);
      chk("e_drain_pending", pending_o, 0);
      chk("e_drain_done", done_cnt_o, 13);
      chk("e_drain_busy", busy_o, 0);

      // Spurious response, and err set beating err_clr
      rsp_valid_i = 1'b1;
      tick();
      rsp_valid_i = 1'b0;
      chk("f_spurious_err", err_o, 2'b10);
      chk("f_spurious_done", done_cnt_o, 13);
      rsp_valid_i = 1'b1;
      err_clr_i = 1'b1;
      tick();
      rsp_valid_i = 1'b0;
      chk("f_set_beats_clr", err_o, 2'b10);
      tick();
      err_clr_i = 1'b0;
      chk("f_err_cleared", err_o, 0);

      // Reset drops queued work
      set_desc(32'h6000, 32'h7000, 32'd32, 1'b0, 1'b0);
      desc_valid_i = 1'b1;
      tick();
      desc_valid_i = 1'b0;
      chk("g_pre_pending", pending_o, 1);
      chk("g_pre_req_valid", req_valid_o, 1);
      rst_i = 1'b1;
      tick();
      chk("g_rst_pending", pending_o, 0);
      chk("g_rst_req_valid", req_valid_o, 0);
      chk("g_rst_done", done_cnt_o, 0);
      chk("g_rst_desc_ready", desc_ready_o, 0);
      rst_i = 1'b0;
      tick();
      chk("g_post_desc_ready", desc_ready_o, 1);

      // Completion counter wrap via zero-length descriptors
      set_desc(32'h0, 32'h0, 32'd0, 1'b0, 1'b0);
      desc_valid_i = 1'b1;
      for (int i = 0; i < 65535; i++) tick();
      desc_valid_i = 1'b0;
      tick();
      chk("h_done_ffff", done_cnt_o, 16'hFFFF);
      chk("h_pending0", pending_o, 0);
      desc_valid_i = 1'b1;
      tick();
      desc_valid_i = 1'b0;
      tick();
      chk("h_done_wrap", done_cnt_o, 16'h0000);
      chk("h_irq", irq_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
